// File: rtl/pingpong_fm_buffer.sv
// Two-bank ping-pong feature-map buffer between LeNet5 layer engines.
// Ports: clk/reset(async low)/flush; producer wr_*/pb_rd_*;
// consumer rd_*; status wr_bank/rd_bank/full_count/err_*.
module pingpong_fm_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 25,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_last,
  output logic                  wr_ready,
  input  logic                  pb_rd_en,
  input  logic [ADDR_WIDTH-1:0] pb_rd_addr,
  output logic [DATA_WIDTH-1:0] pb_rd_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rd_avail,
  input  logic                  rd_release,
  output logic                  wr_bank,
  output logic                  rd_bank,
  output logic [1:0]            full_count,
  output logic                  err_overflow,
  output logic                  err_underflow
);

  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [2][DEPTH];

  logic [1:0] full_q, full_n;
  logic       wb_q, wb_n;
  logic       rb_q, rb_n;

  logic wr_in, rd_in, pb_in;
  logic wr_ok, rd_ok, rel_ok;

  assign wr_in = {1'b0, wr_addr} < DEPTH_W;
  assign rd_in = {1'b0, rd_addr} < DEPTH_W;
  assign pb_in = {1'b0, pb_rd_addr} < DEPTH_W;

  assign wr_ok  = wr_en & wr_ready & wr_in;
  assign rd_ok  = rd_en & rd_avail & rd_in;
  assign rel_ok = rd_release & rd_avail;

  // bank state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full_q <= 2'b00;
      wb_q   <= 1'b0;
      rb_q   <= 1'b0;
    end else begin
      full_q <= full_n;
      wb_q   <= wb_n;
      rb_q   <= rb_n;
    end
  end

  // completion and release never hit the same bank: one needs it
  // empty, the other needs it full
  always_comb begin
    full_n = full_q;
    wb_n   = wb_q;
    rb_n   = rb_q;
    if (flush) begin
      full_n = 2'b00;
      wb_n   = 1'b0;
      rb_n   = 1'b0;
    end else begin
      if (wr_ok && wr_last) begin
        full_n[wb_q] = 1'b1;
        wb_n         = ~wb_q;
      end
      if (rel_ok) begin
        full_n[rb_q] = 1'b0;
        rb_n         = ~rb_q;
      end
    end
  end

  always_comb begin
    wr_ready   = ~full_q[wb_q];
    rd_avail   = full_q[rb_q];
    full_count = 2'(full_q[0]) + 2'(full_q[1]);
    wr_bank    = wb_q;
    rd_bank    = rb_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < DEPTH; i++) begin
          mem[b][i] <= '0;
        end
      end
    end else if (wr_ok && !flush) begin
      mem[wb_q][wr_addr] <= wr_data;
    end
  end

  // reads sample mem before this edge's write lands
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_ok & ~flush;
      if (rd_ok && !flush) begin
        rd_data <= mem[rb_q][rd_addr];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pb_rd_data <= '0;
    end else if (pb_rd_en && !flush) begin
      pb_rd_data <= pb_in ? mem[wb_q][pb_rd_addr] : '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else if (!flush) begin
      if (wr_en && !wr_ok) begin
        err_overflow <= 1'b1;
      end
      if ((rd_en && !rd_ok) || (rd_release && !rd_avail)) begin
        err_underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pingpong_fm_buffer.sv
// Scoreboard bench for pingpong_fm_buffer.
// Read and readback expectations are queued; a monitor checks them.
module tb_pingpong_fm_buffer;

  localparam int DW = 16;
  localparam int AW = 5;

  logic          clk;
  logic          reset;
  logic          flush;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_last;
  logic          wr_ready;
  logic          pb_rd_en;
  logic [AW-1:0] pb_rd_addr;
  logic [DW-1:0] pb_rd_data;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_avail;
  logic          rd_release;
  logic          wr_bank;
  logic          rd_bank;
  logic [1:0]    full_count;
  logic          err_overflow;
  logic          err_underflow;

  int n_cmp = 0;
  int n_err = 0;

  int rd_q[$];
  int pb_q[$];
  logic pb_v;

  pingpong_fm_buffer #(
    .DATA_WIDTH(DW),
    .DEPTH(25),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .wr_last(wr_last),
    .wr_ready(wr_ready),
    .pb_rd_en(pb_rd_en),
    .pb_rd_addr(pb_rd_addr),
    .pb_rd_data(pb_rd_data),
    .rd_en(rd_en),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .rd_valid(rd_valid),
    .rd_avail(rd_avail),
    .rd_release(rd_release),
    .wr_bank(wr_bank),
    .rd_bank(rd_bank),
    .full_count(full_count),
    .err_overflow(err_overflow),
    .err_underflow(err_underflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // readback has no valid output; track an issued request here
  always @(posedge clk or negedge reset) begin
    if (!reset) pb_v <= 1'b0;
    else pb_v <= pb_rd_en & ~flush;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        if (rd_valid) begin
          if (rd_q.size() == 0) chk("rd_spurious", 1, 0);
          else chk("rd_data", int'(rd_data), rd_q.pop_front());
        end
        if (pb_v) begin
          if (pb_q.size() == 0) chk("pb_spurious", 1, 0);
          else chk("pb_rd_data", int'(pb_rd_data), pb_q.pop_front());
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    wr_en      = 1'b0;
    wr_last    = 1'b0;
    rd_en      = 1'b0;
    rd_release = 1'b0;
    pb_rd_en   = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic set_wr(input int a, input int d, input bit l);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = DW'(d);
    wr_last = l;
  endtask

  task automatic exp_rd(input int a, input int e);
    rd_en   = 1'b1;
    rd_addr = AW'(a);
    rd_q.push_back(e);
  endtask

  task automatic exp_pb(input int a, input int e);
    pb_rd_en   = 1'b1;
    pb_rd_addr = AW'(a);
    pb_q.push_back(e);
  endtask

  task automatic chk_status(input string tag, input int wb, input int rb,
                            input int fc, input int wrdy, input int av);
    chk({tag, "_wr_bank"}, int'(wr_bank), wb);
    chk({tag, "_rd_bank"}, int'(rd_bank), rb);
    chk({tag, "_full_count"}, int'(full_count), fc);
    chk({tag, "_wr_ready"}, int'(wr_ready), wrdy);
    chk({tag, "_rd_avail"}, int'(rd_avail), av);
  endtask

  task automatic chk_reset(input string tag);
    chk_status(tag, 0, 0, 0, 1, 0);
    chk({tag, "_rd_valid"}, int'(rd_valid), 0);
    chk({tag, "_rd_data"}, int'(rd_data), 0);
    chk({tag, "_pb_rd_data"}, int'(pb_rd_data), 0);
    chk({tag, "_err_ovf"}, int'(err_overflow), 0);
    chk({tag, "_err_unf"}, int'(err_underflow), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset      = 1'b0;
    flush      = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    wr_last    = 1'b0;
    pb_rd_en   = 1'b0;
    pb_rd_addr = '0;
    rd_en      = 1'b0;
    rd_addr    = '0;
    rd_release = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("rst");
    reset = 1'b1;

    // fill bank 0 with 100+i
    for (int i = 0; i < 25; i++) begin
      set_wr(i, 100 + i, i == 24);
      cyc();
    end
    chk_status("fill0", 1, 0, 1, 1, 1);
    exp_rd(7, 107);
    cyc();

    // fill bank 1 while draining bank 0; last + release together
    for (int i = 0; i < 24; i++) begin
      set_wr(i, 200 + i, 0);
      exp_rd(i, 100 + i);
      cyc();
    end
    set_wr(24, 224, 1);
    exp_rd(24, 124);
    rd_release = 1'b1;
    cyc();
    chk_status("swap", 0, 1, 1, 1, 1);
    exp_rd(3, 203);
    cyc();

    // fill bank 0 again without release: both full
    for (int i = 0; i < 25; i++) begin
      set_wr(i, 100 + i, i == 24);
      cyc();
    end
    chk_status("both", 1, 1, 2, 0, 1);
    set_wr(0, 999, 0);
    cyc();
    chk("ovf_full", int'(err_overflow), 1);
    chk("unf_clean", int'(err_underflow), 0);
    rd_release = 1'b1;
    cyc();
    chk_status("rel1", 1, 0, 1, 1, 1);
    exp_rd(0, 100);
    exp_pb(0, 200);
    cyc();

    // readback during write returns old data
    set_wr(5, 10, 0);
    cyc();
    set_wr(5, 20, 0);
    exp_pb(5, 10);
    cyc();
    exp_pb(5, 20);
    cyc();
    exp_pb(30, 0);
    cyc();
    chk("unf_still0", int'(err_underflow), 0);

    // empty the read side, then misuse it
    rd_release = 1'b1;
    cyc();
    chk_status("rel0", 1, 1, 0, 1, 0);
    chk("unf_before", int'(err_underflow), 0);
    rd_en      = 1'b1;
    rd_addr    = '0;
    rd_release = 1'b1;
    set_wr(30, 1, 0);
    cyc();
    chk("unf_set", int'(err_underflow), 1);
    chk("ovf_set", int'(err_overflow), 1);
    chk("rd_valid_bad", int'(rd_valid), 0);
    chk("rd_bank_bad", int'(rd_bank), 1);

    // flush wins over a same-cycle completing write
    flush = 1'b1;
    set_wr(2, 555, 1);
    cyc();
    chk_status("flush", 0, 0, 0, 1, 0);
    chk("flush_ovf", int'(err_overflow), 1);
    chk("flush_unf", int'(err_underflow), 1);
    for (int i = 0; i < 25; i++) begin
      set_wr(i, 300 + i, i == 24);
      cyc();
    end
    chk_status("fill3", 1, 0, 1, 1, 1);
    exp_pb(2, 202);
    exp_rd(2, 302);
    cyc();

    // reset in the middle of a fill
    for (int i = 0; i < 10; i++) begin
      set_wr(i, 400 + i, 0);
      cyc();
    end
    reset = 1'b0;
    #1;
    chk_reset("midrst");
    cyc();
    reset = 1'b1;
    exp_pb(3, 0);
    cyc();
    cyc();
    chk_reset("post");

    cyc();
    chk("rd_q_drain", rd_q.size(), 0);
    chk("pb_q_drain", pb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pingpong_fm_buffer.md
Name: pingpong_fm_buffer

Overview:
- Parametrised two-bank (ping-pong) feature-map buffer between consecutive LeNet5 layer engines.
- Generalises the single-word double register to DEPTH-word banks, with per-bank full/empty tracking and automatic bank swap.
- Adds producer/consumer handshakes, a producer readback port for partial-sum accumulation, flush, and sticky error flags.
- The producer layer fills one bank while the next layer drains the other.

Parameters:
DATA_WIDTH, 16, word width (fixed-point activation/partial sum)
DEPTH, 25, words per bank (e.g. one 5x5 map)
ADDR_WIDTH, 5, address width; must satisfy 2**ADDR_WIDTH >= DEPTH

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
flush  input  1  synchronous clear of bank state (contents kept)
wr_en  input  1  producer write strobe
wr_addr  input  ADDR_WIDTH  producer write address
wr_data  input  DATA_WIDTH  producer write data
wr_last  input  1  with accepted wr_en: final word, bank complete
wr_ready  output  1  current write bank is empty/filling
pb_rd_en  input  1  producer readback strobe (write bank)
pb_rd_addr  input  ADDR_WIDTH  producer readback address
pb_rd_data  output  DATA_WIDTH  producer readback data, 1-cycle latency
rd_en  input  1  consumer read strobe (read bank)
rd_addr  input  ADDR_WIDTH  consumer read address
rd_data  output  DATA_WIDTH  consumer read data, 1-cycle latency
rd_valid  output  1  rd_data updated this cycle
rd_avail  output  1  current read bank is full
rd_release  input  1  consumer done with read bank
wr_bank  output  1  index of bank being written
rd_bank  output  1  index of bank being read
full_count  output  2  number of full banks (0..2)
err_overflow  output  1  sticky: write rejected (not ready or addr >= DEPTH)
err_underflow  output  1  sticky: read/release while !rd_avail, or rd addr >= DEPTH

Behaviour:
- State: full[1:0], wr_bank, rd_bank, memory mem[2][DEPTH].
- Reset (async, reset=0):
  - full=0, wr_bank=0, rd_bank=0, full_count=0.
  - mem cleared to 0.
  - rd_data=0, pb_rd_data=0, rd_valid=0, both err flags 0.
  - Outputs wr_ready=1, rd_avail=0.
- Combinational outputs: wr_ready = !full[wr_bank]; rd_avail = full[rd_bank]; full_count = full[0]+full[1].
- Write acceptance: wr_en & wr_ready & (wr_addr < DEPTH) writes mem[wr_bank][wr_addr] at the edge.
  - Otherwise the write is dropped and err_overflow is set.
- Bank completion: accepted write with wr_last sets full[wr_bank] and toggles wr_bank at the same edge. The next cycle's writes target the other bank.
  - wr_last without an accepted write is ignored.
- Release: rd_release & rd_avail clears full[rd_bank] and toggles rd_bank.
  - rd_release & !rd_avail is ignored and sets err_underflow.
- Consumer read:
  - rd_en & rd_avail & (rd_addr < DEPTH): rd_data <= mem[rd_bank][rd_addr], rd_valid=1 next cycle.
  - Else rd_valid=0 and rd_data holds. An invalid rd_en sets err_underflow.
- Producer readback: pb_rd_en: pb_rd_data <= mem[wr_bank][pb_rd_addr] (0 if addr >= DEPTH), 1-cycle latency. Otherwise holds.
- Read-during-write, same bank and address: the read returns the old (pre-write) data.
- Simultaneous events:
  - wr_last and rd_release in the same cycle act on different banks by construction; both take effect.
  - full_count is unchanged in that case.
  - rd_en with rd_release in the same cycle reads the pre-swap bank.
- Both banks full: wr_ready=0 and producer writes are rejected until a release.
- Flush: full=0, wr_bank=0, rd_bank=0, rd_valid=0. mem, err flags and data outputs are unchanged. flush overrides all same-cycle writes/releases.
- Reset mid-operation: immediate return to reset values. No partial bank survives.
- Error flags clear only on reset.

Test Plan:
- Reset, write 25 words value 100+i to bank 0 with wr_last on addr 24 -> wr_bank=1, rd_avail=1, full_count=1; consumer reads addr 7 -> rd_data=107, rd_valid=1 one cycle after rd_en.
- Fill bank 1 (200+i) while draining bank 0, release bank 0 and wr_last in the same cycle -> rd_bank=1, wr_bank=0, full_count stays 1; read addr 3 returns 203.
- Fill both banks without release -> wr_ready=0, full_count=2; extra write to addr 0 is dropped, err_overflow=1, and bank-0 addr 0 still reads 100.
- Producer write addr 5 = 10, then pb_rd_en addr 5 in the same cycle as a write of 20 -> pb_rd_data=10; next readback -> 20.
- rd_en and rd_release with rd_avail=0, and write to addr 30 -> err_underflow=1, err_overflow=1, rd_valid=0; flush -> banks empty, flags still 1.
- Assert reset mid-fill (after 10 words) -> all outputs at reset values, wr_bank=0, readback of addr 3 returns 0.
